// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Contents: XLEN, INSTR_BYTES, ALIGN_MASK, fetch_entry_t {pc, instr}.
// Imported by fetch_fifo and rom_fetch_unit.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // Clears the byte-offset bits so every fetch address is word aligned.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries for the decode stage.
// Ports: clk/rst (sync, active high), flush, push/push_data, pop, head, empty, count.
// Latency: a pushed entry is visible at head the cycle after the push; flush empties in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Pointer wrap that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop & ~empty;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    do_push = push & (~full | do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/rom_fetch_unit.sv
// Reader side of a 1-cycle registered instruction ROM; issues word-aligned fetches,
// tracks the single in-flight read and buffers returned words for decode over valid/ready.
// Ports: clk, rst (sync, active high), run, redirect_valid/redirect_addr, rom_addr/rom_en/rom_data,
//        out_valid/out_ready/out_pc/out_instr. Latency: issue in cycle N -> out_valid in N+2.
module rom_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic [31:0] rom_addr,
  output logic        rom_en,
  input  logic [31:0] rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int               CW       = $clog2(FIFO_DEPTH + 1);
  localparam int               UW       = CW + 1;
  localparam logic [XLEN-1:0]  RESET_PC = RESET_ADDR & ALIGN_MASK;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tag_pc;
  logic            inflight;

  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            pop;
  logic            push;
  logic            issue;
  logic [UW-1:0]   used;

  always_comb begin
    pop  = ~fifo_empty & out_ready;
    // Slots already committed: buffered words plus the read still coming back.
    // The head leaving this cycle frees its slot, which is what lets a
    // two-entry buffer sustain one word per cycle.
    used  = UW'(fifo_count) + UW'(inflight) - UW'(pop);
    issue = ~rst & run & ~redirect_valid & (used < UW'(FIFO_DEPTH));
    // A redirect kills the word returning this cycle: it belongs to the old stream.
    push  = inflight & ~redirect_valid;
    push_data.pc    = tag_pc;
    push_data.instr = rom_data;
  end

  assign rom_en   = issue;
  assign rom_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      tag_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_addr & ALIGN_MASK;
      inflight <= 1'b0;
    end else if (issue) begin
      pc       <= pc + XLEN'(INSTR_BYTES);
      tag_pc   <= pc;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs read as zero whenever nothing valid is buffered.
  always_comb begin
    out_valid = ~fifo_empty;
    out_pc    = fifo_empty ? '0 : head.pc;
    out_instr = fifo_empty ? '0 : head.instr;
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
module tb_rom_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h2222_2222;
  localparam logic [31:0] W2 = 32'h3333_3333;
  localparam logic [31:0] W3 = 32'h4444_4444;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return W0;
      32'h4:   return W1;
      32'h8:   return W2;
      32'hC:   return W3;
      default: return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // DUT A: RESET_ADDR = 0
  logic        rst_a = 1'b1, run_a = 1'b0, rv_a = 1'b0, rdy_a = 1'b1;
  logic [31:0] ra_a = '0;
  logic [31:0] rom_addr_a, rom_data_a = '0, out_pc_a, out_instr_a;
  logic        rom_en_a, out_valid_a;

  rom_fetch_unit #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst_a), .run(run_a), .redirect_valid(rv_a), .redirect_addr(ra_a),
    .rom_addr(rom_addr_a), .rom_en(rom_en_a), .rom_data(rom_data_a),
    .out_valid(out_valid_a), .out_ready(rdy_a), .out_pc(out_pc_a), .out_instr(out_instr_a)
  );

  always @(posedge clk) if (rom_en_a) rom_data_a <= rom_word(rom_addr_a);

  // DUT B: RESET_ADDR at the top of the address space
  logic        rst_b = 1'b1, run_b = 1'b0, rdy_b = 1'b1;
  logic        rv_b = 1'b0;
  logic [31:0] ra_b = '0;
  logic [31:0] rom_addr_b, rom_data_b = '0, out_pc_b, out_instr_b;
  logic        rom_en_b, out_valid_b;

  rom_fetch_unit #(.RESET_ADDR(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .run(run_b), .redirect_valid(rv_b), .redirect_addr(ra_b),
    .rom_addr(rom_addr_b), .rom_en(rom_en_b), .rom_data(rom_data_b),
    .out_valid(out_valid_b), .out_ready(rdy_b), .out_pc(out_pc_b), .out_instr(out_instr_b)
  );

  always @(posedge clk) if (rom_en_b) rom_data_b <= rom_word(rom_addr_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        run;
    logic        rv;
    logic [31:0] ra;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] opc;
    logic [31:0] oin;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic run, input logic rv, input logic [31:0] ra,
                              input logic rdy, input logic en, input logic [31:0] addr, input logic ov,
                              input logic [31:0] opc, input logic [31:0] oin);
    vec_t v;
    v.rst = rst; v.run = run; v.rv = rv; v.ra = ra; v.rdy = rdy;
    v.en = en; v.addr = addr; v.ov = ov; v.opc = opc; v.oin = oin;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    // Streaming from reset, first word two cycles after first rom_en
    vecs.push_back(mk(1,1,0,0,1, 0,32'h0, 0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h0, 0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h4, 0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h8, 1,32'h0,W0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'hC, 1,32'h4,W1));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,1,32'h8,W2));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,1,32'hC,W3));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,0,32'h0,'0));
    // Consumer stall for six cycles: credit stops issue, head holds, no loss on release
    vecs.push_back(mk(1,0,0,0,1, 0,32'h10,0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h0, 0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h4, 0,32'h0,'0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0,1,0,0,0, 0,32'h8, 1,32'h0,W0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h8, 1,32'h0,W0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'hC, 1,32'h4,W1));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,1,32'h8,W2));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,1,32'hC,W3));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,0,32'h0,'0));
    // Redirect to 0x9 while pc 4 is in flight: pc 4 is dropped, stream resumes at 0x8
    vecs.push_back(mk(1,0,0,0,1, 0,32'h10,0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h0, 0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h4, 0,32'h0,'0));
    vecs.push_back(mk(0,1,1,32'h9,0, 0,32'h8, 1,32'h0,W0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h8, 0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'hC, 0,32'h0,'0));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,1,32'h8,W2));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,1,32'hC,W3));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,0,32'h0,'0));
    // Redirect to 0xE coincident with handshake of pc 0
    vecs.push_back(mk(1,0,0,0,1, 0,32'h10,0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h0, 0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'h4, 0,32'h0,'0));
    vecs.push_back(mk(0,1,1,32'hE,1, 0,32'h8, 1,32'h0,W0));
    vecs.push_back(mk(0,1,0,0,1, 1,32'hC, 0,32'h0,'0));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,0,32'h0,'0));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,1,32'hC,W3));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h10,0,32'h0,'0));
    // Reset with FIFO full, then reset with a read in flight
    vecs.push_back(mk(1,0,0,0,0, 0,32'h10,0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,0, 1,32'h0, 0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,0, 1,32'h4, 0,32'h0,'0));
    vecs.push_back(mk(0,1,0,0,0, 0,32'h8, 1,32'h0,W0));
    vecs.push_back(mk(1,1,0,0,0, 0,32'h8, 1,32'h0,W0));
    vecs.push_back(mk(0,1,0,0,0, 1,32'h0, 0,32'h0,'0));
    vecs.push_back(mk(1,1,0,0,0, 0,32'h4, 0,32'h0,'0));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h0, 0,32'h0,'0));
    vecs.push_back(mk(0,0,0,0,1, 0,32'h0, 0,32'h0,'0));

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_a = vecs[i].rst; run_a = vecs[i].run; rv_a = vecs[i].rv;
      ra_a  = vecs[i].ra;  rdy_a = vecs[i].rdy;
      #1;
      check($sformatf("row%0d rom_en", i),    {31'b0, rom_en_a},    {31'b0, vecs[i].en});
      check($sformatf("row%0d rom_addr", i),  rom_addr_a,            vecs[i].addr);
      check($sformatf("row%0d out_valid", i), {31'b0, out_valid_a}, {31'b0, vecs[i].ov});
      check($sformatf("row%0d out_pc", i),    out_pc_a,              vecs[i].opc);
      check($sformatf("row%0d out_instr", i), out_instr_a,           vecs[i].oin);
    end

    // PC wrap from 0xFFFF_FFFC to 0 on the second instance
    begin
      logic        b_run [6];
      logic        b_en  [6];
      logic [31:0] b_addr[6];
      logic        b_ov  [6];
      logic [31:0] b_pc  [6];
      logic [31:0] b_in  [6];
      b_run  = '{1, 1, 1, 0, 0, 0};
      b_en   = '{1, 1, 1, 0, 0, 0};
      b_addr = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'h8, 32'h8};
      b_ov   = '{0, 0, 1, 1, 1, 0};
      b_pc   = '{32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h0};
      b_in   = '{32'h0, 32'h0, 32'h5A5A_5A59, W0, W1, 32'h0};

      @(negedge clk);
      rst_b = 1'b1; run_b = 1'b1; rdy_b = 1'b1;
      #1;
      check("wrap reset rom_en",   {31'b0, rom_en_b},    32'h0);
      check("wrap reset rom_addr", rom_addr_b,            32'hFFFF_FFFC);
      check("wrap reset out_valid",{31'b0, out_valid_b}, 32'h0);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        rst_b = 1'b0; run_b = b_run[k];
        #1;
        check($sformatf("wrap%0d rom_en", k),    {31'b0, rom_en_b},    {31'b0, b_en[k]});
        check($sformatf("wrap%0d rom_addr", k),  rom_addr_b,            b_addr[k]);
        check($sformatf("wrap%0d out_valid", k), {31'b0, out_valid_b}, {31'b0, b_ov[k]});
        check($sformatf("wrap%0d out_pc", k),    out_pc_b,              b_pc[k]);
        check($sformatf("wrap%0d out_instr", k), out_instr_b,           b_in[k]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
